// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: parallel-word front end for a serial sequence detector.
// Each accepted W-bit word is shifted MSB-first onto det_bit, one bit per clock.
// The detector's hits are counted per word, and the count is returned over a
// valid/ready handshake.
// Optional feature macro: HIT_MASK_EN adds out_mask, which marks the word
// position of every hit.
module seq_det_ctrl #(
  parameter int W             = 8,
  parameter int DET_LAT       = 0,
  parameter int CLEAR_BETWEEN = 1,
  localparam int CW           = $clog2(W + 1),
  localparam int BW           = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_bit,
  output logic          det_en,
  output logic          det_clr,
  input  logic          det_hit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count
`ifdef HIT_MASK_EN
  ,
  output logic [W-1:0]  out_mask
`endif
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [BW-1:0] bitidx_d1_q;
  logic          det_en_d1_q;
  logic [CW-1:0] count_q, count_d;
  logic          accept, hit_take;
  logic [BW-1:0] hit_idx;
`ifdef HIT_MASK_EN
  logic [W-1:0]  mask_q, mask_d;
`endif

  assign accept = (state_q == IDLE) && in_valid;

  // A Moore detector reports the previous bit's hit, so both the qualifier and
  // the bit position are taken one cycle late.
  assign hit_take = (DET_LAT == 0) ? (det_en & det_hit) : (det_en_d1_q & det_hit);
  assign hit_idx  = (DET_LAT == 0) ? bitcnt_q : bitidx_d1_q;

  // State register plus datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      bitidx_d1_q <= '0;
      det_en_d1_q <= 1'b0;
      count_q     <= '0;
`ifdef HIT_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      bitidx_d1_q <= bitcnt_q;
      det_en_d1_q <= det_en;
      count_q     <= count_d;
`ifdef HIT_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (CLEAR_BETWEEN != 0) ? CLR : SHIFT;
      CLR:     state_d = SHIFT;
      SHIFT:   if (bitcnt_q == BW'(W - 1)) state_d = (DET_LAT != 0) ? DRAIN : DONE;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; det_bit is forced low outside SHIFT
  always_comb begin
    in_ready  = (state_q == IDLE);
    det_clr   = (state_q == CLR);
    det_en    = (state_q == SHIFT);
    det_bit   = (state_q == SHIFT) & shreg_q[W-1];
    out_valid = (state_q == DONE);
  end

  // Shift register, bit counter, and hit accumulation
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
`ifdef HIT_MASK_EN
    mask_d   = mask_q;
`endif
    if (accept) begin
      shreg_d  = in_data;
      bitcnt_d = '0;
      count_d  = '0;
`ifdef HIT_MASK_EN
      mask_d   = '0;
`endif
    end else if (state_q == SHIFT) begin
      shreg_d  = {shreg_q[W-2:0], 1'b0};
      bitcnt_d = bitcnt_q + 1'b1;
    end
    // hit_take is only possible in SHIFT or DRAIN, so it never collides with accept
    if (hit_take) begin
      count_d = count_q + 1'b1;
`ifdef HIT_MASK_EN
      mask_d[W-1-int'(hit_idx)] = 1'b1;
`endif
    end
  end

  assign out_count = count_q;
`ifdef HIT_MASK_EN
  assign out_mask  = mask_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl.
// Three instances are built: Mealy with clear, Moore with clear, and Mealy
// without clear. Each instance drives its own overlapping "101" detector model.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic       det_bit   [3];
  logic       det_en    [3];
  logic       det_clr   [3];
  logic       det_hit   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [3:0] out_count [3];
`ifdef HIT_MASK_EN
  logic [7:0] out_mask  [3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int DL = (g == 1) ? 1 : 0;
    localparam int CB = (g == 2) ? 0 : 1;

    seq_det_ctrl #(.W(8), .DET_LAT(DL), .CLEAR_BETWEEN(CB)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .det_bit   (det_bit[g]),
      .det_en    (det_en[g]),
      .det_clr   (det_clr[g]),
      .det_hit   (det_hit[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_count (out_count[g])
`ifdef HIT_MASK_EN
      ,
      .out_mask  (out_mask[g])
`endif
    );

    // Detector model state encoding:
    //   0 = nothing seen, 1 = "1", 2 = "10", 3 = "101" (Moore hit state).
    logic [1:0] s;

    always_ff @(posedge clk or posedge rst[g]) begin
      if (rst[g])            s <= 2'd0;
      else if (det_clr[g])   s <= 2'd0;
      else if (det_en[g]) begin
        case (s)
          2'd0:    s <= det_bit[g] ? 2'd1 : 2'd0;
          2'd1:    s <= det_bit[g] ? 2'd1 : 2'd2;
          2'd2:    s <= det_bit[g] ? ((DL != 0) ? 2'd3 : 2'd1) : 2'd0;
          default: s <= det_bit[g] ? 2'd1 : 2'd2;
        endcase
      end
    end

    assign det_hit[g] = (DL != 0) ? (s == 2'd3) : (det_en[g] & det_bit[g] & (s == 2'd2));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one word through instance n and checks latency, count, mask, and handshake.
  // If hold > 0, out_ready is held low in DONE for that many cycles while a
  // competing word is offered on the input.
  task automatic run_word(input int n, input logic [7:0] w, input int exp_cnt,
                          input logic [7:0] exp_mask, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    in_data[n]  = w;
    in_valid[n] = 1'b1;
    chk("rdy_idle", in_ready[n], 1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        in_valid[n] = 1'b0;
        if (n != 2) chk("clr_cycle", {det_clr[n], det_en[n]}, 2'b10);
        else        chk("shift_noclr", {det_clr[n], det_en[n]}, 2'b01);
      end
    end while (!out_valid[n] && lat < 40);
    chk("latency", lat, exp_lat);
    chk("count", out_count[n], exp_cnt);
`ifdef HIT_MASK_EN
    chk("mask", out_mask[n], exp_mask);
`else
    if (exp_mask === 8'hxx) $display("unreachable");
`endif
    chk("rdy_done", in_ready[n], 0);
    if (hold > 0) begin
      @(negedge clk);
      in_data[n]  = ~w;
      in_valid[n] = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("hold_vld", out_valid[n], 1);
        chk("hold_cnt", out_count[n], exp_cnt);
        chk("hold_rdy", in_ready[n], 0);
      end
      in_valid[n] = 1'b0;
    end
    @(negedge clk);
    out_ready[n] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[n] = 1'b0;
    chk("post_vld", out_valid[n], 0);
    chk("post_rdy", in_ready[n], 1);
    chk("cnt_kept", out_count[n], exp_cnt);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      out_ready[i] = 1'b0;
    end

    // Reset state, with in_valid asserted to show it is ignored while reset is held
    in_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready[0], 1);
    chk("rst_bit", det_bit[0], 0);
    chk("rst_en",  det_en[0], 0);
    chk("rst_clr", det_clr[0], 0);
    chk("rst_vld", out_valid[0], 0);
    chk("rst_cnt", out_count[0], 0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Mealy detector with clear: alternating bits give three overlapping hits
    run_word(0, 8'hAA, 3, 8'h2A, 10, 0);
    run_word(0, 8'h00, 0, 8'h00, 10, 0);
    run_word(0, 8'hFF, 0, 8'h00, 10, 0);

    // Moore detector: the final-bit hit is taken in DRAIN
    run_word(1, 8'h05, 1, 8'h01, 11, 0);
    run_word(1, 8'hAA, 3, 8'h2A, 11, 0);

    // Back-pressure in DONE
    run_word(0, 8'h05, 1, 8'h01, 10, 5);
    @(posedge clk);
    #1;
    chk("no_steal", in_ready[0], 1);

    // Reset asserted during SHIFT at bit 3
    @(negedge clk);
    in_data[0]  = 8'hAA;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_en", det_en[0], 1);
    rst[0] = 1'b1;
    #1;
    chk("arst_rdy", in_ready[0], 1);
    chk("arst_en",  det_en[0], 0);
    @(posedge clk);
    #1;
    chk("rst_edge_rdy", in_ready[0], 1);
    chk("rst_edge_en",  det_en[0], 0);
    chk("rst_edge_vld", out_valid[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    run_word(0, 8'hAA, 3, 8'h2A, 10, 0);

    // A "101" spanning a word boundary counts only when detector state is kept
    run_word(2, 8'h02, 0, 8'h00, 9, 0);
    run_word(2, 8'h80, 1, 8'h80, 9, 0);
    run_word(0, 8'h02, 0, 8'h00, 10, 0);
    run_word(0, 8'h80, 0, 8'h00, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
